exp2_halve_pipe: RTL and testbench

- Decode-side counterpart of the exp2 doubling pipeline.
- The doubling pipeline shifts each 100-bit word through ten stages and doubles it at every stage, so a word leaves scaled by 2^10 (mod 2^100).
- This block shifts each valid word through DEPTH registered stages and halves it at every stage (logical shift right by 1). It also keeps a sticky flag that records any 1 bits shifted out.
- It sits on the receive path after the doubling pipeline, adds stall control and occupancy tracking, and recovers the original word.

---
 rtl/exp2_halve_pipe.sv | 60 ++++++
 tb/tb_exp2_halve_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/exp2_halve_pipe.sv
// rtl/exp2_halve_pipe.sv - DEPTH-stage halving pipeline with sticky inexact flag, stall and occupancy
module exp2_halve_pipe #(
    parameter int W     = 100,
    parameter int DEPTH = 10,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  __in0,
    input  logic          __in1,
    input  logic          __in2,
    output logic [W-1:0]  __out0,
    output logic          __out1,
    output logic          __out2,
    output logic [CW-1:0] __out3
);

    logic [W-1:0]     d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] s;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    occNext;

    // The last stage is consumed on every advancing edge, so entry and exit cancel.
    always_comb begin
        occNext = occ;
        case ({__in1, v[DEPTH-1]})
            2'b10:   occNext = occ + CW'(1);
            2'b01:   occNext = occ - CW'(1);
            default: occNext = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
            v   <= '0;
            s   <= '0;
            occ <= '0;
        end else if (!__in2) begin
            d[0] <= __in0 >> 1;
            s[0] <= __in0[0];
            v[0] <= __in1;
            for (int i = 1; i < DEPTH; i++) begin
                d[i] <= d[i-1] >> 1;
                s[i] <= s[i-1] | d[i-1][0];
                v[i] <= v[i-1];
            end
            occ <= occNext;
        end
    end

    assign __out0 = d[DEPTH-1];
    assign __out1 = v[DEPTH-1];
    assign __out2 = s[DEPTH-1];
    assign __out3 = occ;

endmodule

// File: tb/tb_exp2_halve_pipe.sv
// tb/tb_exp2_halve_pipe.sv - scoreboard bench for exp2_halve_pipe
module tb_exp2_halve_pipe;

    localparam int W     = 100;
    localparam int DEPTH = 10;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  inData;
    logic          inValid;
    logic          stall;
    logic [W-1:0]  outData;
    logic          outValid;
    logic          outInexact;
    logic [CW-1:0] outOcc;

    logic [W-1:0]  expData;
    logic          expInexact;
    logic          armed = 1'b0;

    int checks = 0;
    int errors = 0;
    int advCnt = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        int           due;
    } ent_t;
    ent_t q[$];

    exp2_halve_pipe #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .__in0  (inData),
        .__in1  (inValid),
        .__in2  (stall),
        .__out0 (outData),
        .__out1 (outValid),
        .__out2 (outInexact),
        .__out3 (outOcc)
    );

    always #5 clk = ~clk;

    // Monitor: inputs are stable at negedge, so it can predict the coming edge too.
    always @(negedge clk) begin
        if (armed) begin
            logic expV;
            ent_t e;
            expV = (q.size() > 0) && (q[0].due == advCnt);
            checks++;
            if (outOcc !== CW'(q.size())) begin
                errors++;
                $display("FAIL occupancy t=%0t got %0d want %0d", $time, outOcc, q.size());
            end
            checks++;
            if (outValid !== expV) begin
                errors++;
                $display("FAIL out_valid t=%0t got %b want %b", $time, outValid, expV);
            end
            if (expV) begin
                checks++;
                if (outData !== q[0].d || outInexact !== q[0].s) begin
                    errors++;
                    $display("FAIL out_word t=%0t got %h/%b want %h/%b",
                             $time, outData, outInexact, q[0].d, q[0].s);
                end
            end
            if (rst) begin
                q.delete();
            end else if (!stall) begin
                if (expV) void'(q.pop_front());
                if (inValid) begin
                    e.d   = expData;
                    e.s   = expInexact;
                    e.due = advCnt + DEPTH;
                    q.push_back(e);
                end
                advCnt++;
            end
        end
    end

    task automatic step(input logic [W-1:0] x, input logic vld, input logic st,
                        input logic [W-1:0] ex, input logic es);
        inData     = x;
        inValid    = vld;
        stall      = st;
        expData    = ex;
        expInexact = es;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    logic [W-1:0] x;
    logic [W-1:0] dbl;
    logic [W-1:0] ones;
    logic [W-1:0] top;

    initial begin
        rst = 1'b1;
        inData = '0; inValid = 1'b0; stall = 1'b0; expData = '0; expInexact = 1'b0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(W'(100'h400), 1'b1, 1'b0, W'(1), 1'b0);
        idle(12);
        step(W'(100'h7FF), 1'b1, 1'b0, W'(1), 1'b1);
        idle(12);
        top = '0; top[99] = 1'b1;
        x = '0; x[89] = 1'b1;
        step(top, 1'b1, 1'b0, x, 1'b0);
        idle(12);
        ones = '1;
        x = '0; x[89:0] = '1;
        step(ones, 1'b1, 1'b0, x, 1'b1);
        step('0, 1'b1, 1'b0, '0, 1'b0);
        idle(12);

        for (int n = 1; n <= 15; n++) step(W'(1024 * n), 1'b1, 1'b0, W'(n), 1'b0);
        idle(12);

        // Stall with four words in flight; the valid offered during stall is dropped.
        for (int n = 1; n <= 4; n++) step(W'(1024 * n + 3), 1'b1, 1'b0, W'(n), 1'b1);
        step(W'(100'h5000), 1'b1, 1'b1, W'(100'h14), 1'b0);
        step('0, 1'b0, 1'b1, '0, 1'b0);
        step('0, 1'b0, 1'b1, '0, 1'b0);
        idle(14);

        // Reset mid-stream, with stall also high: reset must win.
        for (int n = 1; n <= 6; n++) step(W'(1024 * n), 1'b1, 1'b0, W'(n), 1'b0);
        rst = 1'b1;
        step(W'(100'h800), 1'b1, 1'b1, W'(2), 1'b0);
        rst = 1'b0;
        step(W'(100'hC00), 1'b1, 1'b0, W'(3), 1'b0);
        idle(12);

        // Round trip through a modelled doubling pipeline (x << DEPTH mod 2^W).
        for (int i = 0; i < 1000; i++) begin
            x = {4'h0, $urandom, $urandom, $urandom};
            x[W-1:90] = '0;
            dbl = x << DEPTH;
            step(dbl, 1'b1, 1'b0, x, 1'b0);
            if (i % 97 == 96) idle(3);
        end
        for (int i = 0; i < 20; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            dbl = x << DEPTH;
            x[W-1:90] = '0;
            step(dbl, 1'b1, 1'b0, x, 1'b0);
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
        end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
